data_swapper: RTL and testbench

- Clocked two-lane datapath element. It either passes a pair of N-bit words straight through or crosses them, under control of swap_en.
- Sits between a producer and a consumer on a valid/ready stream.
- Registers the selected pair, with one cycle of latency and full-throughput backpressure via a 2-entry skid buffer.
- Keeps a saturating count of swapped transfers for debug/status.

---
 rtl/data_swapper_pkg.sv | 12 +
 rtl/swap_skid_buf.sv | 74 +++++++
 rtl/data_swapper.sv | 78 +++++++
 tb/tb_data_swapper.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/data_swapper_pkg.sv
// Shared constants and the lane-pair bundle for the data swapper.
package data_swapper_pkg;

    localparam int N_DEF     = 8;
    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic [N_DEF-1:0] a;
        logic [N_DEF-1:0] b;
    } pair_t;

endpackage

// File: rtl/swap_skid_buf.sv
// Two-entry valid/ready skid buffer with registered outputs and ready.
module swap_skid_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q, in_ready_d;
    logic         in_fire;
    logic         main_free;

    assign in_fire   = in_valid && in_ready_q;
    assign main_free = !main_valid_q || out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        unique case (1'b1)
            skid_valid_q && out_ready: begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
            !skid_valid_q && in_fire && main_free: begin
                main_d       = in_data;
                main_valid_d = 1'b1;
            end
            !skid_valid_q && in_fire && !main_free: begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end
            !skid_valid_q && !in_fire && main_valid_q && out_ready: begin
                main_valid_d = 1'b0;
            end
            default: begin
            end
        endcase
        // Ready is a pure function of next-cycle skid occupancy.
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/data_swapper.sv
// Two-lane pass/cross element on a valid/ready stream with a
// saturating count of swapped transfers.
module data_swapper
    import data_swapper_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in1,
    input  logic [N-1:0]     in2,
    input  logic             swap_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out1,
    output logic [N-1:0]     out2,
    output logic [CNT_W-1:0] swap_cnt,
    input  logic             clr_cnt
);

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
    } lane_pair_t;

    lane_pair_t       sel_pair;
    lane_pair_t       held_pair;
    logic             in_fire;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sel_pair.a = swap_en ? in2 : in1;
        sel_pair.b = swap_en ? in1 : in2;
    end

    swap_skid_buf #(
        .W (2*N)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (sel_pair),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (held_pair)
    );

    assign out1    = held_pair.a;
    assign out2    = held_pair.b;
    assign in_fire = in_valid && in_ready;

    // Clear wins over a same-cycle increment; no wrap at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        unique case (1'b1)
            clr_cnt: cnt_d = '0;
            !clr_cnt && in_fire && swap_en && !(&cnt_q):
                cnt_d = cnt_q + CNT_W'(1);
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign swap_cnt = cnt_q;

endmodule

// File: tb/tb_data_swapper.sv
// Randomized and directed bench for data_swapper against a queue model.
module tb_data_swapper;
    import data_swapper_pkg::*;

    localparam int N = N_DEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         swap_en = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_cnt = 1'b0;
    logic [N-1:0] in1 = '0;
    logic [N-1:0] in2 = '0;

    logic         in_ready, out_valid;
    logic [N-1:0] out1, out2;
    logic [15:0]  swap_cnt;
    logic         in_ready_w2, out_valid_w2;
    logic [N-1:0] out1_w2, out2_w2;
    logic [1:0]   swap_cnt_w2;

    pair_t       q[$];
    int unsigned cnt16 = 0;
    int unsigned cnt2 = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    data_swapper #(.N(N), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .swap_en   (swap_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .out2      (out2),
        .swap_cnt  (swap_cnt),
        .clr_cnt   (clr_cnt)
    );

    data_swapper #(.N(N), .CNT_W(2)) dut_w2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w2),
        .in1       (in1),
        .in2       (in2),
        .swap_en   (swap_en),
        .out_valid (out_valid_w2),
        .out_ready (out_ready),
        .out1      (out1_w2),
        .out2      (out2_w2),
        .swap_cnt  (swap_cnt_w2),
        .clr_cnt   (clr_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit exp_rdy;
        bit exp_vld;
        exp_rdy = (q.size() < 2);
        exp_vld = (q.size() > 0);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("out_valid", out_valid, exp_vld);
        check_eq("in_ready_w2", in_ready_w2, exp_rdy);
        check_eq("out_valid_w2", out_valid_w2, exp_vld);
        if (exp_vld) begin
            check_eq("out1", out1, q[0].a);
            check_eq("out2", out2, q[0].b);
            check_eq("out1_w2", out1_w2, q[0].a);
        end
        check_eq("swap_cnt", swap_cnt, cnt16);
        check_eq("swap_cnt_w2", swap_cnt_w2, cnt2);
    endtask

    // One clock: check current state, drive inputs, advance the model.
    task automatic cycle(input bit iv, input logic [N-1:0] d1,
                         input logic [N-1:0] d2, input bit sw,
                         input bit ordy, input bit clr);
        bit    acc;
        bit    drn;
        pair_t p;
        check_outputs();
        in_valid  = iv;
        in1       = d1;
        in2       = d2;
        swap_en   = sw;
        out_ready = ordy;
        clr_cnt   = clr;
        acc = iv && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        if (drn) void'(q.pop_front());
        if (acc) begin
            p.a = sw ? d2 : d1;
            p.b = sw ? d1 : d2;
            q.push_back(p);
        end
        if (clr) begin
            cnt16 = 0;
            cnt2  = 0;
        end else if (acc && sw) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt2 < 3) cnt2++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out1", out1, 0);
        check_eq("rst_out2", out2, 0);
        check_eq("rst_swap_cnt", swap_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        cycle(1, 8'hAA, 8'h55, 0, 1, 0);
        check_eq("tp_pass_out1", out1, 8'hAA);
        check_eq("tp_pass_out2", out2, 8'h55);
        cycle(1, 8'hAA, 8'h55, 1, 1, 0);
        check_eq("tp_swap_out1", out1, 8'h55);
        check_eq("tp_swap_cnt", swap_cnt, 1);
        cycle(1, 8'h0F, 8'hF0, 0, 1, 0);
        check_eq("tp_b2b_out1_a", out1, 8'h0F);
        cycle(1, 8'h0F, 8'hF0, 1, 1, 0);
        check_eq("tp_b2b_out1_b", out1, 8'hF0);
        check_eq("tp_b2b_cnt", swap_cnt, 2);

        cycle(0, 8'h00, 8'h00, 0, 1, 0);
        cycle(1, 8'h11, 8'h22, 0, 0, 0);
        cycle(1, 8'h33, 8'h44, 0, 0, 0);
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_hold_out1", out1, 8'h11);
        cycle(1, 8'h55, 8'h66, 0, 0, 0);
        check_eq("bp_still_out1", out1, 8'h11);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 8'h00, 0, 1, 0);

        for (int i = 0; i < 5; i++)
            cycle(1, N'($urandom), N'($urandom), 1, 1, 0);
        check_eq("sat_cnt_w2", swap_cnt_w2, 3);
        cycle(1, 8'h12, 8'h34, 1, 1, 1);
        check_eq("clr_prio_cnt_w2", swap_cnt_w2, 0);
        check_eq("clr_prio_cnt", swap_cnt, 0);

        cycle(0, 8'h00, 8'h00, 0, 1, 0);
        cycle(1, 8'hC1, 8'hC2, 0, 0, 0);
        cycle(1, 8'hD1, 8'hD2, 1, 0, 0);
        check_eq("pre_rst_in_ready", in_ready, 0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_out1", out1, 0);
        check_eq("arst_out2", out2, 0);
        q.delete();
        cnt16 = 0;
        cnt2  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 8'h00, 1, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(3) != 0), N'($urandom), N'($urandom),
                  1'($urandom), ($urandom_range(4) > 1),
                  ($urandom_range(63) == 0));
        end
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 8'h00, 0, 1, 0);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
